// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the front end.
// Holds default datapath widths, the bubble encoding, the fetch FSM state
// type and the opcodes the fetch/decode boundary cares about.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // All-zero word; the decoder treats it as NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n      - system clock, async active-low reset
//   i_load          - capture i_instr / i_pc_plus4 as a valid instruction
//   i_bubble        - replace contents with a NOP bubble (wins over i_load)
//   i_instr         - instruction word to capture
//   i_pc_plus4      - PC+4 of that instruction
//   o_instr         - registered instruction
//   o_pc_plus4      - registered PC+4
//   o_valid         - register holds a real instruction
// With neither i_load nor i_bubble asserted the register holds.
module if_id_reg #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc_plus4,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_valid
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic              r_valid;

  // A bubble keeps pc_plus4 so a later jump still sees a sensible region.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= DATA_W'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register.
// Owns the PC, issues req/ready fetches to instruction memory and hands the
// returned word to the decoder through if_id_reg.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   imem_req_out / imem_addr_out     - fetch request and word address
//   imem_ready_in / imem_rdata_in    - memory accept strobe and data
//   stall_in, flush_in               - hazard hold / IF/ID bubble
//   branch_taken_in/branch_target_in - branch redirect (priority)
//   jump_in / jump_index_in          - J-type redirect
//   instr_out, pc_plus4_out, valid_out - IF/ID contents
//   op_out, func_out                 - decoder field slices of instr_out
//
// state   | meaning
// S_IDLE  | one cycle after reset, memory responses ignored
// S_FETCH | request at pc outstanding, accept on ready
// S_DROP  | redirect seen while waiting; discard old response
// S_HOLD  | stalled with a fetched word parked in the skid buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = cpu_pkg::ADDR_W,
  parameter int          DATA_W   = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_ready_in,
  input  logic [DATA_W-1:0] imem_rdata_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              branch_taken_in,
  input  logic [ADDR_W-1:0] branch_target_in,
  input  logic              jump_in,
  input  logic [25:0]       jump_index_in,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  output logic              valid_out,
  output logic [5:0]        op_out,
  output logic [5:0]        func_out
);
  import cpu_pkg::*;

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pc_redirect, w_redir_nxt;
  logic [DATA_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0] r_skid_pc4;

  logic              w_skid_we;
  logic              w_load;
  logic              w_bubble;
  logic              w_req;
  logic [DATA_W-1:0] w_load_instr;
  logic [ADDR_W-1:0] w_load_pc4;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc4_ifid;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_j_target;

  assign w_pc_inc    = r_pc + ADDR_W'(4);
  assign w_br_target = branch_target_in & ~ADDR_W'(3);
  // The jump sits in IF/ID, so its region comes from the IF/ID PC+4.
  assign w_j_target  = {w_pc4_ifid[ADDR_W-1:28], jump_index_in, 2'b00};
  assign w_redirect  = branch_taken_in | jump_in;
  // Branch is the older instruction, so it wins over a same-cycle jump.
  assign w_target    = branch_taken_in ? w_br_target : w_j_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= ADDR_W'(RESET_PC);
      r_pc_redirect <= ADDR_W'(RESET_PC);
      r_skid_instr  <= '0;
      r_skid_pc4    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pc_redirect <= w_redir_nxt;
      if (w_skid_we) begin
        r_skid_instr <= imem_rdata_in;
        r_skid_pc4   <= w_pc_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_redir_nxt  = r_pc_redirect;
    w_skid_we    = 1'b0;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_req        = 1'b0;
    w_load_instr = imem_rdata_in;
    w_load_pc4   = w_pc_inc;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (w_redirect) begin
          w_bubble = 1'b1;
          if (imem_ready_in) begin
            w_pc_nxt = w_target;
          end else begin
            w_redir_nxt = w_target;
            w_state_nxt = S_DROP;
          end
        end else if (stall_in) begin
          w_bubble = flush_in;
          if (imem_ready_in) begin
            w_skid_we   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_HOLD;
          end
        end else if (imem_ready_in) begin
          w_pc_nxt = w_pc_inc;
          w_bubble = flush_in;
          w_load   = 1'b1;
        end else begin
          // Nothing arrived this cycle; downstream must not re-see the old word.
          w_bubble = 1'b1;
        end
      end
      S_DROP: begin
        w_req    = 1'b1;
        w_bubble = 1'b1;
        if (w_redirect) begin
          w_redir_nxt = w_target;
        end
        if (imem_ready_in) begin
          w_pc_nxt    = w_redirect ? w_target : r_pc_redirect;
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_bubble    = 1'b1;
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!stall_in) begin
          w_bubble     = flush_in;
          w_load       = 1'b1;
          w_load_instr = r_skid_instr;
          w_load_pc4   = r_skid_pc4;
          w_state_nxt  = S_FETCH;
        end else begin
          w_bubble = flush_in;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_instr    (w_load_instr),
    .i_pc_plus4 (w_load_pc4),
    .o_instr    (instr_out),
    .o_pc_plus4 (w_pc4_ifid),
    .o_valid    (valid_out)
  );

  assign pc_plus4_out  = w_pc4_ifid;
  assign imem_req_out  = w_req;
  assign imem_addr_out = r_pc;
  assign op_out        = instr_out[31:26];
  assign func_out      = instr_out[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic [31:0] imem_rdata_in;
  logic        stall_in;
  logic        flush_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        jump_in;
  logic [25:0] jump_index_in;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic [5:0]  op_out;
  logic [5:0]  func_out;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_ready_in    (imem_ready_in),
    .imem_rdata_in    (imem_rdata_in),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .jump_in          (jump_in),
    .jump_index_in    (jump_index_in),
    .instr_out        (instr_out),
    .pc_plus4_out     (pc_plus4_out),
    .valid_out        (valid_out),
    .op_out           (op_out),
    .func_out         (func_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push what the IF/ID register should show once this word is accepted.
  task automatic accept_word(input logic [31:0] data);
    exp_t e;
    e.instr = data;
    e.pc4   = imem_addr_out + 32'd4;
    sb_q.push_back(e);
    imem_ready_in = 1'b1;
    imem_rdata_in = data;
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: scoreboard empty, instr_out=%h", tag, instr_out);
    end else begin
      e = sb_q.pop_front();
      if (valid_out !== 1'b1 || instr_out !== e.instr || pc_plus4_out !== e.pc4) begin
        n_err++;
        $display("FAIL %s_ifid: got v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                 tag, valid_out, instr_out, pc_plus4_out, e.instr, e.pc4);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready_in = 1'b0; imem_rdata_in = '0; stall_in = 1'b0; flush_in = 1'b0;
    branch_taken_in = 1'b0; branch_target_in = '0; jump_in = 1'b0; jump_index_in = '0;
    repeat (3) step();
    n_cmp++;
    if ({imem_req_out, valid_out, instr_out, pc_plus4_out} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_vals: got req=%b v=%b instr=%h pc4=%h expected all 0",
               imem_req_out, valid_out, instr_out, pc_plus4_out);
    end
    rst_n = 1'b1;
    n_cmp++;
    if (imem_req_out !== 1'b0) begin
      n_err++;
      $display("FAIL idle_req: got %b expected 0", imem_req_out);
    end
    step();
    n_cmp++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      n_err++;
      $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=0", imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_zero_wait();
    accept_word(32'h0000_0020);
    step();
    pop_and_check("zw0");
    n_cmp++;
    if (imem_addr_out !== 32'h4) begin
      n_err++;
      $display("FAIL zw_addr4: got %h expected 4", imem_addr_out);
    end
    accept_word(32'h0000_0022);
    step();
    imem_ready_in = 1'b0;
    pop_and_check("zw1");
    n_cmp++;
    if (imem_addr_out !== 32'h8) begin
      n_err++;
      $display("FAIL zw_addr8: got %h expected 8", imem_addr_out);
    end
  endtask

  task automatic test_flush();
    imem_ready_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF; flush_in = 1'b1;
    step();
    imem_ready_in = 1'b0; flush_in = 1'b0;
    n_cmp++;
    if (instr_out !== 32'h0 || valid_out !== 1'b0 || imem_addr_out !== 32'hC) begin
      n_err++;
      $display("FAIL flush: got instr=%h v=%b addr=%h expected 0 0 c", instr_out, valid_out, imem_addr_out);
    end
  endtask

  task automatic test_jump_drop();
    step();
    jump_in = 1'b1; jump_index_in = 26'h10;
    step();
    jump_in = 1'b0;
    step();
    n_cmp++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hC || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL drop_wait: got req=%b addr=%h v=%b expected 1 c 0", imem_req_out, imem_addr_out, valid_out);
    end
    imem_ready_in = 1'b1; imem_rdata_in = 32'h0BAD_0BAD;
    step();
    imem_ready_in = 1'b0;
    n_cmp++;
    if (imem_addr_out !== 32'h40 || valid_out !== 1'b0 || instr_out !== 32'h0) begin
      n_err++;
      $display("FAIL drop_done: got addr=%h v=%b instr=%h expected 40 0 0", imem_addr_out, valid_out, instr_out);
    end
    accept_word(32'h0000_1234);
    step();
    imem_ready_in = 1'b0;
    pop_and_check("after_drop");
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    accept_word(32'h8C01_0004);
    step();
    imem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (instr_out !== 32'h0000_1234 || valid_out !== 1'b1 || imem_req_out !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got instr=%h v=%b req=%b expected 1234 1 0",
                 i, instr_out, valid_out, imem_req_out);
      end
      step();
    end
    stall_in = 1'b0;
    step();
    pop_and_check("unstall");
    n_cmp++;
    if (op_out !== 6'b100011 || func_out !== 6'h04 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h48) begin
      n_err++;
      $display("FAIL unstall_fields: got op=%b func=%h req=%b addr=%h expected 100011 04 1 48",
               op_out, func_out, imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_branch_jump();
    branch_taken_in = 1'b1; branch_target_in = 32'h0000_0103;
    jump_in = 1'b1; jump_index_in = 26'h3FF_FFFF;
    imem_ready_in = 1'b1; imem_rdata_in = 32'h5555_5555;
    step();
    branch_taken_in = 1'b0; jump_in = 1'b0; imem_ready_in = 1'b0;
    n_cmp++;
    if (imem_addr_out !== 32'h100 || instr_out !== 32'h0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL br_prio: got addr=%h instr=%h v=%b expected 100 0 0", imem_addr_out, instr_out, valid_out);
    end
  endtask

  task automatic test_wrap();
    branch_taken_in = 1'b1; branch_target_in = 32'hFFFF_FFFF;
    imem_ready_in = 1'b1; imem_rdata_in = 32'h1111_1111;
    step();
    branch_taken_in = 1'b0; imem_ready_in = 1'b0;
    n_cmp++;
    if (imem_addr_out !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr_out);
    end
    accept_word(32'h0000_0077);
    step();
    imem_ready_in = 1'b0;
    pop_and_check("wrap");
    n_cmp++;
    if (imem_addr_out !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: got %h expected 0", imem_addr_out);
    end
  endtask

  task automatic test_hold_redirect();
    stall_in = 1'b1; imem_ready_in = 1'b1; imem_rdata_in = 32'h0000_0099;
    step();
    imem_ready_in = 1'b0;
    n_cmp++;
    if (imem_req_out !== 1'b0) begin
      n_err++;
      $display("FAIL hold_req: got %b expected 0", imem_req_out);
    end
    branch_taken_in = 1'b1; branch_target_in = 32'h0000_0200;
    step();
    branch_taken_in = 1'b0; stall_in = 1'b0;
    n_cmp++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL hold_redir: got req=%b addr=%h v=%b expected 1 200 0", imem_req_out, imem_addr_out, valid_out);
    end
    accept_word(32'h0000_0300);
    step();
    imem_ready_in = 1'b0;
    pop_and_check("post_hold");
  endtask

  task automatic test_reset_mid_drop();
    jump_in = 1'b1; jump_index_in = 26'h20;
    step();
    jump_in = 1'b0;
    n_cmp++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h204) begin
      n_err++;
      $display("FAIL pre_rst_drop: got req=%b addr=%h expected 1 204", imem_req_out, imem_addr_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_out, valid_out, instr_out, pc_plus4_out, imem_addr_out} !== 98'd0) begin
      n_err++;
      $display("FAIL async_rst: got req=%b v=%b instr=%h pc4=%h addr=%h expected all 0",
               imem_req_out, valid_out, instr_out, pc_plus4_out, imem_addr_out);
    end
    imem_ready_in = 1'b1; imem_rdata_in = 32'hFFFF_FFFF;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (valid_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      n_err++;
      $display("FAIL post_rst: got v=%b req=%b addr=%h expected 0 1 0", valid_out, imem_req_out, imem_addr_out);
    end
    imem_ready_in = 1'b0;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_flush();
    test_jump_drop();
    test_stall();
    test_branch_jump();
    test_wrap();
    test_hold_redirect();
    test_reset_mid_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
